// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority pick: first set request at or above ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Scan N slots starting at ptr; the first hit wins.
  always_comb begin
    int k;
    k   = 0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        idx = IDW'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port between N producers.
// Grants bursts of up to MAX_BURST beats; one IDLE bubble per arbitration.
// Optional per-producer beat counters: define FIFO_WR_ARBITER_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  localparam int IDW      = clog2(N),
  localparam int CW       = clog2(MAX_BURST) + 1
) (
  input  logic                clk,
  input  logic                rstn,
`ifdef FIFO_WR_ARBITER_STATS_EN
  input  logic                stat_clr,
  output logic [N*STAT_W-1:0] stat_beats,
`endif
  input  logic [N-1:0]        req_valid,
  input  logic [N*W-1:0]      req_data,
  output logic [N-1:0]        req_ready,
  input  logic                fifo_full,
  output logic                fifo_w_en,
  output logic [W-1:0]        fifo_data_in,
  output logic [IDW-1:0]      grant_id,
  output logic                busy
);

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_owner, w_owner_nxt;
  logic [IDW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [CW-1:0]  r_beat_cnt, w_beat_cnt_nxt;

  logic [IDW-1:0] w_pick_idx;
  logic           w_pick_any;
  logic           w_busy, w_own_valid, w_beat, w_last;
  logic [W-1:0]   w_own_data;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  assign w_busy      = (r_state == BURST);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_data  = req_data[r_owner*W +: W];
  assign w_beat      = w_busy && w_own_valid && !fifo_full;
  assign w_last      = (r_beat_cnt == CW'(MAX_BURST - 1));

  // Datapath outputs decoded from the registered owner.
  always_comb begin
    req_ready          = '0;
    req_ready[r_owner] = w_beat;
    fifo_w_en          = w_beat;
    fifo_data_in       = w_busy ? w_own_data : '0;
    grant_id           = r_owner;
    busy               = w_busy;
  end

  // Next-state: grant in IDLE, count/stall/release in BURST.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_owner_nxt    = w_pick_idx;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = BURST;
        end
      end
      BURST: begin
        // A dropped valid or the final beat hands the pointer past the owner.
        if (!w_own_valid || (w_beat && w_last)) begin
          w_rr_ptr_nxt   = (r_owner == IDW'(N - 1)) ? '0 : r_owner + 1'b1;
          w_beat_cnt_nxt = '0;
          w_state_nxt    = IDLE;
        end else if (w_beat) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        end
        // fifo_full with valid high: hold everything until the FIFO drains.
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [N-1:0][STAT_W-1:0] r_stat;

  // Saturating accepted-beat counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (stat_clr)
          r_stat[i] <= '0;
        else if (req_ready[i] && req_valid[i] && r_stat[i] != STAT_MAX)
          r_stat[i] <= r_stat[i] + 1'b1;
      end
    end
  end

  assign stat_beats = r_stat;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N=4, W=8, MAX_BURST=4).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_beats;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N(4), .W(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
`ifdef FIFO_WR_ARBITER_STATS_EN
    .stat_clr     (stat_clr),
    .stat_beats   (stat_beats),
`endif
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set: check this cycle, advance to next negedge.
  task automatic cyc(input string tag, input logic bsy, input logic we,
                     input logic [3:0] rdy, input logic [1:0] gid, input logic [7:0] dat);
    #1;
    chk({tag, ".busy"}, busy, bsy);
    chk({tag, ".w_en"}, fifo_w_en, we);
    chk({tag, ".ready"}, req_ready, rdy);
    chk({tag, ".data"}, fifo_data_in, dat);
    if (bsy) chk({tag, ".gid"}, grant_id, gid);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rstn      = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [9:0]  s1_we, s1_bsy;
    logic [13:0] s3_we, s3_bsy;
    int k;
`ifdef FIFO_WR_ARBITER_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset state, with requests pending so data must still read 0.
    rstn      = 1'b0;
    fifo_full = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    @(negedge clk);
    cyc("rst", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    chk("rst.gid", grant_id, 2'd0);

    // S1: producer 2 alone, six beats A0..A5 -> 4 beats, bubble, 2 beats, release.
    do_reset();
    s1_we  = 10'b0011011110;
    s1_bsy = 10'b0111011110;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (k < 6) ? 4'b0100 : 4'b0000;
      req_data  = {8'h00, 8'hA0 + 8'(k), 16'h0000};
      cyc("s1", s1_bsy[c], s1_we[c], s1_we[c] ? 4'b0100 : 4'b0000, 2'd2,
          s1_bsy[c] ? 8'hA0 + 8'(k) : 8'h00);
      if (s1_we[c]) k++;
    end

    // S2: all producers continuously; 5-cycle period, order 0,1,2,3,0...
    do_reset();
    req_valid = 4'hF;
    req_data  = 32'h44332211;
    for (int c = 0; c < 200; c++) begin
      int ph, own;
      ph  = c % 5;
      own = (c / 5) % 4;
      cyc("s2", ph != 0, ph != 0, (ph != 0) ? 4'(1 << own) : 4'h0, 2'(own),
          (ph != 0) ? 8'(8'h11 * (own + 1)) : 8'h00);
    end
`ifdef FIFO_WR_ARBITER_STATS_EN
    req_valid = '0;
    for (int i = 0; i < 4; i++) chk("stat.40", stat_beats[i*16 +: 16], 16'd40);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("stat.clr", stat_beats[i*16 +: 16], 16'd0);
`endif

    // S3: producer 1 owns, FIFO full for 7 cycles after beat 2, then producer 2.
    do_reset();
    req_valid = 4'b0110;
    req_data  = 32'h00BB_AA00;
    s3_we  = 14'b10_1100_0000_0110;
    s3_bsy = 14'b10_1111_1111_1110;
    for (int c = 0; c < 14; c++) begin
      logic [1:0] g;
      fifo_full = (c >= 3 && c <= 9);
      g = (c >= 13) ? 2'd2 : 2'd1;
      cyc("s3", s3_bsy[c], s3_we[c], s3_we[c] ? 4'(1 << g) : 4'h0, g,
          s3_bsy[c] ? ((g == 2'd2) ? 8'hBB : 8'hAA) : 8'h00);
    end
    fifo_full = 1'b0;

    // S4: producer 3 drops after one beat; producer 0 (waiting) is next.
    do_reset();
    req_data = 32'hD300_00D0;
    req_valid = 4'b1000; cyc("s4.c0", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    req_valid = 4'b1001; cyc("s4.c1", 1'b1, 1'b1, 4'b1000, 2'd3, 8'hD3);
    req_valid = 4'b0001; cyc("s4.c2", 1'b1, 1'b0, 4'b0000, 2'd3, 8'hD3);
    cyc("s4.c3", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    cyc("s4.c4", 1'b1, 1'b1, 4'b0001, 2'd0, 8'hD0);

    // S5: reset lands on beat 2 of producer 1; afterwards search restarts at 0.
    do_reset();
    req_valid = 4'b0011;
    req_data  = 32'h0000_E1E0;
    cyc("s5.idle", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    for (int c = 0; c < 4; c++) cyc("s5.p0", 1'b1, 1'b1, 4'b0001, 2'd0, 8'hE0);
    cyc("s5.bub", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    cyc("s5.b1", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hE1);
    rstn = 1'b0;
    cyc("s5.rst", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    cyc("s5.rst2", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    rstn = 1'b1;
    cyc("s5.post", 1'b0, 1'b0, 4'h0, 2'd0, 8'h00);
    cyc("s5.g0", 1'b1, 1'b1, 4'b0001, 2'd0, 8'hE0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
